lr_predict: RTL and testbench

- Sequential forward-path engine: computes y_hat = b + sum_i(w_i * x_i) in fixed point (default Q16.16).
- Produces the y_hat consumed by sgd_update, so it is the producing end of that interface.
- Serial single-MAC datapath, one feature per cycle.
- valid/ready handshake on both input and output; output held until accepted.

---
 rtl/lr_predict_pkg.sv | 13 +
 rtl/lr_predict_if.sv | 23 ++
 rtl/lr_predict_mac.sv | 40 ++++
 rtl/lr_predict.sv | 101 ++++++++++
 tb/tb_lr_predict.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/lr_predict_pkg.sv
// lr_predict_pkg: Q-format constants and FSM state encoding for lr_predict.
package lr_predict_pkg;
   localparam int WIDTH = 32;
   localparam int FRACTION = 16;
   localparam logic [WIDTH-1:0] Q_ONE = 32'h0001_0000;
   localparam logic [WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;
   localparam logic [WIDTH-1:0] Q_MIN = 32'h8000_0000;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/lr_predict_if.sv
// lr_predict_if: operand/result valid-ready bus; master drives operands, slave produces y_hat.
interface lr_predict_if #(
   parameter int N_FEATURES = 8,
   parameter int WIDTH = 32
);
   logic                          in_valid;
   logic                          in_ready;
   logic [N_FEATURES*WIDTH-1:0]   x_flat;
   logic [N_FEATURES*WIDTH-1:0]   w_flat;
   logic [WIDTH-1:0]              b_in;
   logic                          out_valid;
   logic                          out_ready;
   logic [WIDTH-1:0]              y_hat;
   logic                          sat_o;
   modport master (
      output in_valid, x_flat, w_flat, b_in, out_ready,
      input  in_ready, out_valid, y_hat, sat_o
   );
   modport slave (
      input  in_valid, x_flat, w_flat, b_in, out_ready,
      output in_ready, out_valid, y_hat, sat_o
   );
endinterface

// File: rtl/lr_predict_mac.sv
// lr_predict_mac: combinational single MAC step acc + w*x with saturation.
// LR_PREDICT_WIDE_ACC_EN selects an unsaturated wide accumulator with one final clamp.
module lr_predict_mac #(
   parameter int WIDTH = 32,
   parameter int FRACTION = 16,
   parameter int AW = 32
) (
   input  logic signed [AW-1:0]    acc_i,
   input  logic signed [WIDTH-1:0] w_i,
   input  logic signed [WIDTH-1:0] x_i,
   output logic signed [AW-1:0]    acc_o,
   output logic [WIDTH-1:0]        y_o,
   output logic                    sat_o
);
   localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] S_MIN = ~S_MAX;
   logic signed [2*WIDTH-1:0] prod;
   assign prod = w_i * x_i;
`ifdef LR_PREDICT_WIDE_ACC_EN
   logic signed [AW-1:0] sh;
   assign acc_o = acc_i + {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
   assign sh = acc_o >>> FRACTION;
   assign sat_o = !(&sh[AW-1:WIDTH-1] || !(|sh[AW-1:WIDTH-1]));
   assign y_o = sat_o ? (sh[AW-1] ? S_MIN : S_MAX) : sh[WIDTH-1:0];
`else
   logic signed [2*WIDTH-1:0] sh;
   logic [WIDTH-1:0] m;
   logic [WIDTH:0] s;
   logic msat, asat;
   assign sh = prod >>> FRACTION;
   assign msat = !(&sh[2*WIDTH-1:WIDTH-1] || !(|sh[2*WIDTH-1:WIDTH-1]));
   assign m = msat ? (sh[2*WIDTH-1] ? S_MIN : S_MAX) : sh[WIDTH-1:0];
   // one guard bit: overflow iff the two top bits of the sum disagree
   assign s = {acc_i[WIDTH-1], acc_i} + {m[WIDTH-1], m};
   assign asat = s[WIDTH] ^ s[WIDTH-1];
   assign acc_o = asat ? (s[WIDTH] ? S_MIN : S_MAX) : s[WIDTH-1:0];
   assign y_o = acc_o;
   assign sat_o = msat | asat;
`endif
endmodule

// File: rtl/lr_predict.sv
// lr_predict: serial forward pass y_hat = b + sum(w_i*x_i), one feature per cycle.
// LR_PREDICT_WIDE_ACC_EN: wide accumulator, saturation applied once at the end.
module lr_predict #(
   parameter int N_FEATURES = 8,
   parameter int WIDTH = lr_predict_pkg::WIDTH,
   parameter int FRACTION = lr_predict_pkg::FRACTION
) (
   input logic         clk,
   input logic         rst,
   lr_predict_if.slave bus
);
   import lr_predict_pkg::*;
   localparam int IW = N_FEATURES > 1 ? $clog2(N_FEATURES) : 1;
`ifdef LR_PREDICT_WIDE_ACC_EN
   localparam int AW = 2*WIDTH + $clog2(N_FEATURES) + 1;
`else
   localparam int AW = WIDTH;
`endif
   state_e state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [AW-1:0] acc_q, acc_d, acc_init, mac_acc;
   logic [WIDTH-1:0] x_q [N_FEATURES];
   logic [WIDTH-1:0] x_d [N_FEATURES];
   logic [WIDTH-1:0] w_q [N_FEATURES];
   logic [WIDTH-1:0] w_d [N_FEATURES];
   logic [WIDTH-1:0] y_q, y_d, mac_y;
   logic sat_q, sat_d, sat_acc_q, sat_acc_d, mac_sat, sat_step, accept, last;
   lr_predict_mac #(.WIDTH(WIDTH), .FRACTION(FRACTION), .AW(AW)) u_mac (
      .acc_i(acc_q),
      .w_i(w_q[idx_q]),
      .x_i(x_q[idx_q]),
      .acc_o(mac_acc),
      .y_o(mac_y),
      .sat_o(mac_sat)
   );
`ifdef LR_PREDICT_WIDE_ACC_EN
   assign acc_init = {{(AW-WIDTH){bus.b_in[WIDTH-1]}}, bus.b_in} << FRACTION;
   assign sat_step = mac_sat;
`else
   assign acc_init = bus.b_in;
   assign sat_step = sat_acc_q | mac_sat;
`endif
   assign bus.in_ready = state_q == IDLE || (state_q == DONE && bus.out_ready);
   assign bus.out_valid = state_q == DONE;
   assign bus.y_hat = y_q;
   assign bus.sat_o = sat_q;
   assign accept = bus.in_valid && bus.in_ready;
   assign last = idx_q == IW'(N_FEATURES - 1);
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      acc_d = acc_q;
      x_d = x_q;
      w_d = w_q;
      y_d = y_q;
      sat_d = sat_q;
      sat_acc_d = sat_acc_q;
      if (state_q == MAC) begin
         acc_d = mac_acc;
         sat_acc_d = sat_step;
         idx_d = last ? '0 : idx_q + 1'b1;
         state_d = last ? DONE : MAC;
         y_d = last ? mac_y : y_q;
         sat_d = last ? sat_step : sat_q;
      end else if (state_q == DONE && bus.out_ready) begin
         state_d = IDLE;
      end
      // a transfer and a new accept may share the same edge
      if (accept) begin
         state_d = MAC;
         idx_d = '0;
         acc_d = acc_init;
         sat_acc_d = 1'b0;
         for (int i = 0; i < N_FEATURES; i++) begin
            x_d[i] = bus.x_flat[i*WIDTH +: WIDTH];
            w_d[i] = bus.w_flat[i*WIDTH +: WIDTH];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q <= '0;
         acc_q <= '0;
         x_q <= '{default: '0};
         w_q <= '{default: '0};
         y_q <= '0;
         sat_q <= 1'b0;
         sat_acc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         acc_q <= acc_d;
         x_q <= x_d;
         w_q <= w_d;
         y_q <= y_d;
         sat_q <= sat_d;
         sat_acc_q <= sat_acc_d;
      end
   end
endmodule

// File: tb/tb_lr_predict.sv
// tb_lr_predict: directed scoreboard bench for lr_predict with N_FEATURES=4.
module tb_lr_predict;
   import lr_predict_pkg::*;
   localparam int N = 4;
   localparam int W = 32;
   typedef struct packed {
      logic [W-1:0] y;
      logic         sat;
   } exp_t;
   localparam logic [N*W-1:0] X1 = {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000};
   localparam logic [N*W-1:0] W1 = {4{32'h0000_8000}};
   localparam logic [N*W-1:0] X3 = {4{32'h0001_0000}};
   localparam logic [N*W-1:0] X4 = {32'h0, 32'h0, 32'h0, 32'h0002_0000};
   localparam logic [N*W-1:0] W4 = {32'h0, 32'h0, 32'h0, 32'h7FFF_0000};
   localparam logic [N*W-1:0] X5 = {32'h0, 32'h0, 32'h0002_0000, 32'h0002_0000};
   localparam logic [N*W-1:0] W5 = {32'h0, 32'h0, 32'h8001_0000, 32'h7FFF_0000};
`ifdef LR_PREDICT_WIDE_ACC_EN
   localparam exp_t E5 = '{y: 32'h0000_0000, sat: 1'b0};
`else
   localparam exp_t E5 = '{y: 32'hFFFF_FFFF, sat: 1'b1};
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   lr_predict_if #(.N_FEATURES(N), .WIDTH(W)) bus ();
   lr_predict #(.N_FEATURES(N), .WIDTH(W), .FRACTION(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // drive operands and hold in_valid until an accepting edge; returns 1 time unit after it
   task automatic send(input logic [N*W-1:0] x, input logic [N*W-1:0] w, input logic [W-1:0] b);
      bus.x_flat = x;
      bus.w_flat = w;
      bus.b_in = b;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus.in_ready) break;
      end
      check("accept_wait", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
   endtask
   task automatic latency(input string tag);
      for (int k = 1; k <= N + 1; k++) begin
         @(negedge clk);
         check(tag, bus.out_valid, k == N + 1);
      end
   endtask
   task automatic wait_out(input string tag);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      check(tag, bus.out_valid, 1'b1);
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", bus.out_valid, 1'b0);
         end else begin
            e = sb.pop_front();
            check("y_hat", bus.y_hat, e.y);
            check("sat_o", bus.sat_o, e.sat);
         end
      end
   end
   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.x_flat = '0;
      bus.w_flat = '0;
      bus.b_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_y_hat", bus.y_hat, 32'h0);
      check("rst_sat_o", bus.sat_o, 1'b0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(X1, W1, Q_ONE);
      sb.push_back('{y: 32'h0006_0000, sat: 1'b0});
      bus.in_valid = 1'b0;
      latency("t1_latency");
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      send(X1, W1, Q_ONE);
      sb.push_back('{y: 32'h0006_0000, sat: 1'b0});
      bus.in_valid = 1'b0;
      latency("t2_latency");
      for (int i = 0; i < 10; i++) begin
         check("t2_hold_valid", bus.out_valid, 1'b1);
         check("t2_hold_y", bus.y_hat, 32'h0006_0000);
         check("t2_hold_sat", bus.sat_o, 1'b0);
         check("t2_hold_in_ready", bus.in_ready, 1'b0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t2_single_transfer", bus.out_valid, 1'b0);
      check("t2_sb_drained", sb.size(), 0);
      @(posedge clk);
      #1;
      send(X1, W1, Q_ONE);
      sb.push_back('{y: 32'h0006_0000, sat: 1'b0});
      bus.x_flat = X3;
      bus.w_flat = X3;
      bus.b_in = 32'h0;
      latency("t3a_latency");
      check("t3_accept_on_transfer", bus.in_ready, 1'b1);
      sb.push_back('{y: 32'h0004_0000, sat: 1'b0});
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      latency("t3b_latency");
      @(posedge clk);
      #1;
      send(X4, W4, 32'h0);
      sb.push_back('{y: Q_MAX, sat: 1'b1});
      bus.in_valid = 1'b0;
      wait_out("t4_sat_timeout");
      send(X1, W1, Q_ONE);
      sb.push_back('{y: 32'h0006_0000, sat: 1'b0});
      bus.in_valid = 1'b0;
      wait_out("t4_clean_timeout");
      send(X5, W5, 32'h0);
      sb.push_back(E5);
      bus.in_valid = 1'b0;
      wait_out("t5_timeout");
      send(X1, W1, Q_ONE);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_out_valid", bus.out_valid, 1'b0);
      check("t6_in_ready", bus.in_ready, 1'b1);
      check("t6_y_hat", bus.y_hat, 32'h0);
      check("t6_sat_o", bus.sat_o, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t6_no_stale", bus.out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      send(X1, W1, Q_ONE);
      sb.push_back('{y: 32'h0006_0000, sat: 1'b0});
      bus.in_valid = 1'b0;
      wait_out("t6_fresh_timeout");
      @(negedge clk);
      check("final_sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
